// File: rtl/tang_leds_pwm_if.sv
// tang_leds_pwm_if: picorv32 native-bus slice used to reach the LED register block.
// Latency: none, wires only.
// Backpressure: master holds leds_sel until the one-cycle leds_ready pulse.
// Ports: leds_sel/leds_addr/leds_we/leds_data_i from master, leds_ready/leds_data_o from slave.
interface tang_leds_pwm_if;
  logic        leds_sel;
  logic [3:0]  leds_addr;
  logic        leds_we;
  logic [31:0] leds_data_i;
  logic        leds_ready;
  logic [31:0] leds_data_o;

  modport master (
    output leds_sel,
    output leds_addr,
    output leds_we,
    output leds_data_i,
    input  leds_ready,
    input  leds_data_o
  );

  modport slave (
    input  leds_sel,
    input  leds_addr,
    input  leds_we,
    input  leds_data_i,
    output leds_ready,
    output leds_data_o
  );
endinterface

// File: rtl/tang_leds_pwm.sv
// tang_leds_pwm: LED register block (on/off, per-channel PWM duty, shared prescaler) for picorv32.
// Latency: leds_ready rises WAIT_STATES+1 cycles after the accepting edge; leds_o lags register state by 1 cycle.
// Backpressure: one access in flight; leds_sel is ignored until the bus FSM is back in IDLE.
// Optional feature: define TANG_LEDS_BLINK_EN to add the BLINK register (index 3) and blink gating.
// Ports: clk, resetn (async active-low), bus (tang_leds_pwm_if.slave), leds_o[NUM_LEDS-1:0] (LED pins).
module tang_leds_pwm #(
  parameter int NUM_LEDS    = 6,
  parameter int PWM_BITS    = 8,
  parameter int WAIT_STATES = 3,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                resetn,
  tang_leds_pwm_if.slave      bus,
  output logic [NUM_LEDS-1:0] leds_o
);

  localparam logic                AL_BIT  = (ACTIVE_LOW != 0);
  localparam logic [NUM_LEDS-1:0] LEDS_OFF = {NUM_LEDS{AL_BIT}};
  localparam logic [PWM_BITS-1:0] PWM_ONE = 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  // Bus FSM state
  bus_state_e  bus_st_q, bus_st_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;

  // Register file
  logic                               ctrl_q, ctrl_d;
  logic [NUM_LEDS-1:0]                led_state_q, led_state_d;
  logic [15:0]                        prescale_q, prescale_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_q, duty_d;

  // PWM timebase
  logic [15:0]         pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_tick;

  // Output stage
  logic [NUM_LEDS-1:0] lit;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

`ifdef TANG_LEDS_BLINK_EN
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic [7:0]          period_q, period_d;
  logic                blink_phase_q, blink_phase_d;
  logic                pwm_wrap;
`endif

  logic        accept;
  logic        wr_en;
  logic [31:0] rd_mux;

  // Upper write-data bits never land in any register field.
  logic unused_wdata;
  assign unused_wdata = ^bus.leds_data_i[31:16];

  assign accept = (bus_st_q == ST_IDLE) && bus.leds_sel;
  assign wr_en  = accept && bus.leds_we;

  // ---------------------------------------------------------------
  // Read mux: unmapped indices and bits beyond each field read 0.
  // ---------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (bus.leds_addr)
      4'd0: rd_mux[0]              = ctrl_q;
      4'd1: rd_mux[NUM_LEDS-1:0]   = led_state_q;
      4'd2: rd_mux[15:0]           = prescale_q;
`ifdef TANG_LEDS_BLINK_EN
      4'd3: rd_mux[NUM_LEDS-1:0]   = blink_q;
`endif
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (bus.leds_addr == 4'(i + 4)) begin
            rd_mux[PWM_BITS-1:0] = duty_q[i];
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Register writes commit on the accepting edge.
  // ---------------------------------------------------------------
  always_comb begin
    ctrl_d      = ctrl_q;
    led_state_d = led_state_q;
    prescale_d  = prescale_q;
    duty_d      = duty_q;
`ifdef TANG_LEDS_BLINK_EN
    blink_d     = blink_q;
`endif
    if (wr_en) begin
      case (bus.leds_addr)
        4'd0: ctrl_d      = bus.leds_data_i[0];
        4'd1: led_state_d = bus.leds_data_i[NUM_LEDS-1:0];
        4'd2: prescale_d  = bus.leds_data_i[15:0];
`ifdef TANG_LEDS_BLINK_EN
        4'd3: blink_d     = bus.leds_data_i[NUM_LEDS-1:0];
`endif
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (bus.leds_addr == 4'(i + 4)) begin
              duty_d[i] = bus.leds_data_i[PWM_BITS-1:0];
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Bus FSM next state. leds_ready is registered out of DONE, so the
  // pulse lands in the cycle after DONE while the FSM already sits in
  // IDLE; that is what gives WAIT_STATES+1 cycles of latency and lets
  // a still-held leds_sel start the next access straight away.
  // WAIT leaves when the counter is about to reach zero.
  // ---------------------------------------------------------------
  always_comb begin
    bus_st_d   = bus_st_q;
    wait_cnt_d = wait_cnt_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    case (bus_st_q)
      ST_IDLE: begin
        if (bus.leds_sel) begin
          if (!bus.leds_we) begin
            rdata_d = rd_mux;
          end
          if (WAIT_STATES == 0) begin
            bus_st_d = ST_DONE;
          end else begin
            bus_st_d   = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          bus_st_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_d  = 1'b1;
        bus_st_d = ST_IDLE;
      end
      default: bus_st_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // PWM timebase. The prescale compare is equality only: if PRESCALE
  // is lowered below the running count, the counter rolls through
  // 0xFFFF back to 0 before the next compare can hit.
  // ---------------------------------------------------------------
  always_comb begin
    pwm_tick  = (pre_cnt_q == prescale_q);
    pre_cnt_d = pwm_tick ? 16'd0 : pre_cnt_q + 16'd1;
    pwm_cnt_d = pwm_tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
  end

`ifdef TANG_LEDS_BLINK_EN
  // Blink phase flips once every 256 full PWM periods.
  always_comb begin
    pwm_wrap      = pwm_tick && (pwm_cnt_q == PWM_MAX);
    period_d      = pwm_wrap ? period_q + 8'd1 : period_q;
    blink_phase_d = (pwm_wrap && (period_q == 8'hFF)) ? ~blink_phase_q : blink_phase_q;
  end
`endif

  // ---------------------------------------------------------------
  // Lit decision and output polarity.
  // ---------------------------------------------------------------
  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      lit[i] = led_state_q[i] && (!ctrl_q || (duty_q[i] > pwm_cnt_q));
`ifdef TANG_LEDS_BLINK_EN
      if (blink_q[i] && !blink_phase_q) begin
        lit[i] = 1'b0;
      end
`endif
    end
    leds_d = lit ^ LEDS_OFF;
  end

  // ---------------------------------------------------------------
  // Bus FSM registers.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_st_q   <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      bus_st_q   <= bus_st_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------------------------------------------------------
  // Register file, PWM counters and LED output registers.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q      <= 1'b0;
      led_state_q <= '0;
      prescale_q  <= 16'd0;
      duty_q      <= '0;
      pre_cnt_q   <= 16'd0;
      pwm_cnt_q   <= '0;
      leds_q      <= LEDS_OFF;
    end else begin
      ctrl_q      <= ctrl_d;
      led_state_q <= led_state_d;
      prescale_q  <= prescale_d;
      duty_q      <= duty_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      leds_q      <= leds_d;
    end
  end

`ifdef TANG_LEDS_BLINK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_q       <= '0;
      period_q      <= 8'd0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_q       <= blink_d;
      period_q      <= period_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  assign bus.leds_ready  = ready_q;
  assign bus.leds_data_o = rdata_q;
  assign leds_o          = leds_q;

endmodule

// File: tb/tb_tang_leds_pwm.sv
// tb_tang_leds_pwm: randomized self-checking bench for tang_leds_pwm against a register/PWM reference model.
// Latency: expects leds_ready WAIT_STATES+1 cycles after acceptance and leds_o one cycle after register writes.
// Backpressure: the bench master holds leds_sel until leds_ready, or keeps it high for back-to-back accesses.
module tb_tang_leds_pwm;
  localparam int NUM_LEDS    = 6;
  localparam int PWM_BITS    = 8;
  localparam int WAIT_STATES = 3;
  localparam int ACTIVE_LOW  = 1;
  localparam bit AL          = (ACTIVE_LOW != 0);
  localparam int PWM_STEPS   = 1 << PWM_BITS;
`ifdef TANG_LEDS_BLINK_EN
  localparam bit BLINK_PRESENT = 1'b1;
`else
  localparam bit BLINK_PRESENT = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [NUM_LEDS-1:0] leds_o;
  int unsigned         cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register file: what software should read back at each index.
  logic [31:0] model_reg [16];

  tang_leds_pwm_if bus();

  tang_leds_pwm #(
    .NUM_LEDS   (NUM_LEDS),
    .PWM_BITS   (PWM_BITS),
    .WAIT_STATES(WAIT_STATES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus),
    .leds_o(leds_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] reg_mask(input logic [3:0] a);
    if (a == 4'd0) return 32'h1;
    if (a == 4'd1) return (32'h1 << NUM_LEDS) - 32'h1;
    if (a == 4'd2) return 32'hFFFF;
    if (a == 4'd3) return BLINK_PRESENT ? (32'h1 << NUM_LEDS) - 32'h1 : 32'h0;
    if (int'(a) >= 4 && int'(a) < 4 + NUM_LEDS) return (32'h1 << PWM_BITS) - 32'h1;
    return 32'h0;
  endfunction

  // Single access; lat counts edges from the accepting edge to the edge that raised leds_ready.
  task automatic bus_access(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus.leds_sel    = 1'b1;
    bus.leds_we     = we;
    bus.leds_addr   = addr;
    bus.leds_data_i = wdata;
    @(posedge clk); #1;
    lat = 0;
    while (bus.leds_ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata        = bus.leds_data_o;
    bus.leds_sel = 1'b0;
    bus.leds_we  = 1'b0;
    if (we) model_reg[addr] = wdata & reg_mask(addr);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (leds_o !== {NUM_LEDS{AL}}) begin
      n_fail++; $display("FAIL reset_leds: got %0h expected %0h", leds_o, {NUM_LEDS{AL}});
    end
    n_checks++;
    if (bus.leds_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %0b expected 0", bus.leds_ready);
    end
    n_checks++;
    if (bus.leds_data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_data_o: got %0h expected 0", bus.leds_data_o);
    end
    resetn = 1'b1;
    for (int a = 0; a < 16; a++) model_reg[a] = 32'h0;
    for (int a = 0; a < 16; a++) begin
      bus_access(1'b0, 4'(a), 32'h0, rd, lat);
      n_checks++;
      if (rd !== model_reg[a]) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %0h expected %0h", a, rd, model_reg[a]);
      end
    end
  endtask

  task automatic test_state_write();
    logic [31:0] rd;
    int lat;
    bus_access(1'b1, 4'd1, 32'h2A, rd, lat);
    n_checks++;
    if (lat !== WAIT_STATES + 1) begin
      n_fail++; $display("FAIL write_latency: got %0d expected %0d", lat, WAIT_STATES + 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.leds_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_one_cycle: got %0b expected 0", bus.leds_ready);
    end
    n_checks++;
    if (leds_o !== (NUM_LEDS'(model_reg[1]) ^ {NUM_LEDS{AL}})) begin
      n_fail++; $display("FAIL state_leds: got %0h expected %0h", leds_o, NUM_LEDS'(model_reg[1]) ^ {NUM_LEDS{AL}});
    end
    bus_access(1'b0, 4'd1, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000002A) begin
      n_fail++; $display("FAIL state_read: got %0h expected 2a", rd);
    end
    n_checks++;
    if (lat !== WAIT_STATES + 1) begin
      n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, WAIT_STATES + 1);
    end
    // Read data must persist across a following write.
    bus_access(1'b1, 4'd5, 32'h77, rd, lat);
    n_checks++;
    if (rd !== 32'h0000002A) begin
      n_fail++; $display("FAIL data_o_hold: got %0h expected 2a", rd);
    end
  endtask

  task automatic test_regs_random();
    logic [31:0] rd, wd;
    logic [3:0] a;
    int lat;
    for (int n = 0; n < 24; n++) begin
      a = 4'($urandom_range(0, 15));
      // PRESCALE and BLINK are exercised in their own tests.
      if (a == 4'd2 || a == 4'd3) a = 4'd15;
      wd = $urandom;
      bus_access(1'b1, a, wd, rd, lat);
      bus_access(1'b0, a, 32'h0, rd, lat);
      n_checks++;
      if (rd !== model_reg[a]) begin
        n_fail++; $display("FAIL reg_rw[%0d]: got %0h expected %0h (wrote %0h)", a, rd, model_reg[a], wd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    int t, gap;
    wd = 32'($urandom_range(0, (1 << NUM_LEDS) - 1));
    @(posedge clk); #1;
    bus.leds_sel = 1'b1; bus.leds_we = 1'b1; bus.leds_addr = 4'd1; bus.leds_data_i = wd;
    t = 0;
    while (bus.leds_ready !== 1'b1 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    gap = 0;
    do begin
      @(posedge clk); #1; gap++;
    end while (bus.leds_ready !== 1'b1 && gap < 40);
    bus.leds_sel = 1'b0; bus.leds_we = 1'b0;
    model_reg[1] = wd & reg_mask(4'd1);
    n_checks++;
    if (gap !== WAIT_STATES + 2) begin
      n_fail++; $display("FAIL back_to_back_gap: got %0d expected %0d", gap, WAIT_STATES + 2);
    end
  endtask

  // Over one full PWM period every channel is lit for a fixed number of
  // cycles regardless of where the period starts.
  task automatic test_pwm(input int p, input int rounds);
    logic [31:0] rd;
    int lat, win, expv;
    logic ctrl;
    logic [NUM_LEDS-1:0] st;
    int duty [NUM_LEDS];
    int lit_cnt [NUM_LEDS];
    bus_access(1'b1, 4'd2, 32'(p), rd, lat);
    win = PWM_STEPS * (p + 1);
    for (int r = 0; r < rounds; r++) begin
      ctrl = (r == rounds - 1 && rounds > 2) ? 1'b0 : 1'b1;
      st = NUM_LEDS'($urandom);
      for (int i = 0; i < NUM_LEDS; i++) duty[i] = $urandom_range(0, PWM_STEPS - 1);
      if (r == 0) begin st[0] = 1'b1; duty[0] = 64; end
      if (r == 1) begin st[0] = 1'b1; duty[0] = 0; st[1] = 1'b1; duty[1] = PWM_STEPS - 1; end
      bus_access(1'b1, 4'd0, {31'($urandom), ctrl}, rd, lat);
      bus_access(1'b1, 4'd1, 32'(st), rd, lat);
      for (int i = 0; i < NUM_LEDS; i++) bus_access(1'b1, 4'(i + 4), 32'(duty[i]), rd, lat);
      repeat (win) @(posedge clk);
      #1;
      for (int i = 0; i < NUM_LEDS; i++) lit_cnt[i] = 0;
      for (int c = 0; c < win; c++) begin
        for (int i = 0; i < NUM_LEDS; i++) if ((leds_o[i] ^ AL) == 1'b1) lit_cnt[i]++;
        @(posedge clk); #1;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        expv = !st[i] ? 0 : (!ctrl ? win : duty[i] * (p + 1));
        n_checks++;
        if (lit_cnt[i] !== expv) begin
          n_fail++;
          $display("FAIL pwm_p%0d_r%0d_ch%0d: got %0d lit cycles expected %0d (duty %0d)", p, r, i, lit_cnt[i], expv, duty[i]);
        end
      end
    end
  endtask

  task automatic test_blink_reg();
    logic [31:0] rd;
    int lat;
    bus_access(1'b1, 4'd3, 32'hFFFF_FFF5, rd, lat);
    bus_access(1'b0, 4'd3, 32'h0, rd, lat);
    n_checks++;
    if (rd !== model_reg[3]) begin
      n_fail++; $display("FAIL blink_reg: got %0h expected %0h", rd, model_reg[3]);
    end
  endtask

  task automatic test_bounds_and_abort();
    logic [31:0] rd;
    int lat;
    bit seen;
    bus_access(1'b1, 4'd2, 32'hABCD_1234, rd, lat);
    bus_access(1'b0, 4'd2, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000_1234) begin
      n_fail++; $display("FAIL prescale_width: got %0h expected 1234", rd);
    end
    bus_access(1'b1, 4'd0, 32'hFFFF_FFFF, rd, lat);
    bus_access(1'b0, 4'd0, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000_0001) begin
      n_fail++; $display("FAIL ctrl_width: got %0h expected 1", rd);
    end
    bus_access(1'b1, 4'd15, 32'hDEAD_BEEF, rd, lat);
    bus_access(1'b0, 4'd15, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got %0h expected 0", rd);
    end
    // Start a write and pull reset while the FSM is waiting.
    @(posedge clk); #1;
    bus.leds_sel = 1'b1; bus.leds_we = 1'b1; bus.leds_addr = 4'd1; bus.leds_data_i = 32'h3F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    bus.leds_sel = 1'b0; bus.leds_we = 1'b0;
    #1;
    n_checks++;
    if (leds_o !== {NUM_LEDS{AL}}) begin
      n_fail++; $display("FAIL abort_leds: got %0h expected %0h", leds_o, {NUM_LEDS{AL}});
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int a = 0; a < 16; a++) model_reg[a] = 32'h0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.leds_ready === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_ready: got ready pulse expected none");
    end
    for (int a = 0; a < 16; a++) begin
      bus_access(1'b0, 4'(a), 32'h0, rd, lat);
      n_checks++;
      if (rd !== model_reg[a]) begin
        n_fail++; $display("FAIL abort_read[%0d]: got %0h expected %0h", a, rd, model_reg[a]);
      end
    end
  endtask

`ifdef TANG_LEDS_BLINK_EN
  // Blink phase starts at 0 on reset release and flips after 256*256 cycles with PRESCALE=0.
  task automatic test_blink_timing(input int unsigned t0);
    logic [31:0] rd;
    int lat;
    bus_access(1'b1, 4'd1, 32'h1, rd, lat);
    bus_access(1'b1, 4'd3, 32'h1, rd, lat);
    while (cyc < t0 + 60000) @(posedge clk);
    #1;
    n_checks++;
    if ((leds_o[0] ^ AL) !== 1'b0) begin
      n_fail++; $display("FAIL blink_first_half: got lit=%0b expected 0", leds_o[0] ^ AL);
    end
    while (cyc < t0 + 67000) @(posedge clk);
    #1;
    n_checks++;
    if ((leds_o[0] ^ AL) !== 1'b1) begin
      n_fail++; $display("FAIL blink_second_half: got lit=%0b expected 1", leds_o[0] ^ AL);
    end
  endtask
`endif

  initial begin
    int unsigned t_rel;
    bus.leds_sel    = 1'b0;
    bus.leds_we     = 1'b0;
    bus.leds_addr   = 4'd0;
    bus.leds_data_i = 32'h0;
    test_reset();
    test_state_write();
    test_regs_random();
    test_back_to_back();
    // Prescale values only ever increase so the counter never has to roll past 0xFFFF.
    test_pwm(0, 4);
    test_pwm(1, 2);
    test_pwm(3, 2);
    test_blink_reg();
    test_bounds_and_abort();
    t_rel = cyc;
`ifdef TANG_LEDS_BLINK_EN
    test_blink_timing(t_rel - 100);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
